// File: rtl/mips_wbmaster_pkg.sv
// Shared definitions for the Wishbone single-transfer master:
// bus widths and the two-state controller encoding.
package mips_wbmaster_pkg;

  localparam int DW = 32;  // Wishbone data width
  localparam int SW = 4;   // byte selects, one per data lane

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } wbm_state_e;

endpackage

// File: rtl/mips_wbm_tmo.sv
// Bus-timeout counter. Cleared when a transfer is accepted, counts every
// cycle the master spends in BUS, and flags expiry during the last allowed
// BUS cycle so the transfer ends after exactly TMO_CYCLES bus cycles.
module mips_wbm_tmo #(
  parameter int TMO_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic busy,
  output logic expired
);

  // Width holds TMO_CYCLES itself, so the single extra increment on the
  // terminating edge cannot wrap.
  localparam int CW = $clog2(TMO_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TMO_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Count BUS cycles; restart on every accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (start) cnt <= '0;
    else if (busy)  cnt <= cnt + 1'b1;
  end

  assign expired = busy & (cnt == LIMIT);

endmodule

// File: rtl/mips_wbmaster.sv
// Wishbone classic single-transfer master for the SSRAM program/data ports.
// Turns a req/rdy/ack CPU handshake into one Wishbone cycle per request.
// Optional build macro MIPS_WBM_TIMEOUT_EN adds a bus-timeout that ends a
// hung transfer as an error after TMO_CYCLES bus cycles.
module mips_wbmaster
  import mips_wbmaster_pkg::*;
#(
  parameter int WADDR      = 13,
  parameter int TMO_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WADDR-1:0] cpu_addr,
  input  logic [DW-1:0]    cpu_wdata,
  input  logic [SW-1:0]    cpu_sel,
  output logic             cpu_rdy,
  output logic             cpu_ack,
  output logic             cpu_err,
  output logic [DW-1:0]    cpu_rdata,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [WADDR-1:0] adr_o,
  output logic [DW-1:0]    dat_o,
  output logic [SW-1:0]    sel_o,
  input  logic [DW-1:0]    dat_i,
  input  logic             ack_i,
  input  logic             err_i
);

  wbm_state_e state, state_nxt;
  logic       in_bus, accept, done, fail, tmo;

  assign cpu_rdy = (state == ST_IDLE);
  assign in_bus  = (state == ST_BUS);
  assign accept  = cpu_rdy & cpu_req;

`ifdef MIPS_WBM_TIMEOUT_EN
  mips_wbm_tmo #(
    .TMO_CYCLES (TMO_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept),
    .busy    (in_bus),
    .expired (tmo)
  );
`else
  // No timeout hardware: a slave that never responds stalls the port.
  assign tmo = (TMO_CYCLES < 0);
`endif

  // Slave responses count only while a cycle is open; err beats ack.
  assign fail = in_bus & (err_i | tmo);
  assign done = in_bus & (ack_i | err_i | tmo);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept in IDLE, return on any termination in BUS.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cpu_req) state_nxt = ST_BUS;
      ST_BUS:  if (done)    state_nxt = ST_IDLE;
      default:              state_nxt = ST_IDLE;
    endcase
  end

  // Registered bus and CPU-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_o     <= 1'b0;
      stb_o     <= 1'b0;
      we_o      <= 1'b0;
      adr_o     <= '0;
      dat_o     <= '0;
      sel_o     <= '0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      cpu_ack <= done;
      cpu_err <= fail;
      if (accept) begin
        cyc_o <= 1'b1;
        stb_o <= 1'b1;
        we_o  <= cpu_we;
        adr_o <= cpu_addr;
        dat_o <= cpu_wdata;
        sel_o <= cpu_sel;
      end else if (done) begin
        cyc_o <= 1'b0;
        stb_o <= 1'b0;
      end
      // Read data is only captured on a clean read completion.
      if (done && !fail && !we_o) cpu_rdata <= dat_i;
    end
  end

endmodule

// File: tb/tb_mips_wbmaster.sv
// Bench for mips_wbmaster: behavioural SSRAM slave with programmable wait
// states / error modes, plus a word-level reference memory used to predict
// read data, latency and error status of every transfer.
module tb_mips_wbmaster;

  localparam int WADDR  = 13;
  localparam int TMO    = 8;
  localparam int BUDGET = 2000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cpu_req, cpu_we;
  logic [WADDR-1:0] cpu_addr;
  logic [31:0]      cpu_wdata;
  logic [3:0]       cpu_sel;
  logic             cpu_rdy, cpu_ack, cpu_err;
  logic [31:0]      cpu_rdata;
  logic             cyc_o, stb_o, we_o;
  logic [WADDR-1:0] adr_o;
  logic [31:0]      dat_o;
  logic [3:0]       sel_o;
  logic [31:0]      dat_i;
  logic             ack_i, err_i;

  int n_chk = 0;
  int n_fail = 0;

  // slave controls: mode 0 ack, 1 err, 2 ack+err, 3 never respond
  int sl_waits = 0;
  int sl_mode  = 0;
  bit sl_spur  = 0;
  int wcnt     = 0;

  logic [31:0] sram    [0:(1<<WADDR)-1];
  logic [31:0] ref_mem [0:(1<<WADDR)-1];
  logic [31:0] ref_rdata;

  always #5 clk = ~clk;

  mips_wbmaster #(.WADDR(WADDR), .TMO_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_sel(cpu_sel),
    .cpu_rdy(cpu_rdy), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
    .dat_o(dat_o), .sel_o(sel_o), .dat_i(dat_i), .ack_i(ack_i),
    .err_i(err_i)
  );

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (sel[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // Slave: responds on the falling edge so the master samples a settled value.
  always @(negedge clk) begin
    ack_i = 1'b0;
    err_i = 1'b0;
    if (cyc_o && stb_o) begin
      if (sl_mode != 3 && wcnt == sl_waits) begin
        case (sl_mode)
          0: begin
            ack_i = 1'b1;
            if (we_o) sram[adr_o] = merge(sram[adr_o], dat_o, sel_o);
            else      dat_i = sram[adr_o];
          end
          1: begin err_i = 1'b1; dat_i = $urandom; end
          default: begin ack_i = 1'b1; err_i = 1'b1; dat_i = $urandom; end
        endcase
      end
      wcnt++;
    end else begin
      wcnt = 0;
      if (sl_spur) begin
        ack_i = 1'b1;
        err_i = 1'b1;
        dat_i = $urandom;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ref_rdata = '0;
  endtask

  // One transfer with full latency / stability / result checks.
  task automatic xfer(input string tag, input logic we, input logic [WADDR-1:0] a,
                      input logic [31:0] wd, input logic [3:0] sel,
                      input int waits, input int mode, input bit noise);
    int lat, stbc, bad;
    bit seen;
    logic [49:0] expbus;
    int exp_lat;
    exp_lat = (mode == 3) ? TMO + 1 : waits + 2;
    @(negedge clk);
    chk({tag, "_rdy"}, cpu_rdy, 1);
    sl_waits  = waits;
    sl_mode   = mode;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
    cpu_sel   = sel;
    expbus    = {we, a, wd, sel};
    @(posedge clk);
    lat = 0; stbc = 0; bad = 0; seen = 0;
    while (!seen && lat < BUDGET) begin
      @(negedge clk);
      lat++;
      if (stb_o) begin
        stbc++;
        if ({we_o, adr_o, dat_o, sel_o} !== expbus || !cyc_o) bad++;
      end
      if (cpu_ack) begin
        seen    = 1;
        cpu_req = 1'b0;
      end else if (noise) begin
        cpu_req   = 1'b1;
        cpu_we    = $urandom;
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
        cpu_sel   = $urandom;
      end else begin
        cpu_req = 1'b0;
      end
    end
    if (!seen) begin
      chk({tag, "_done"}, 0, 1);
      do_reset();
      return;
    end
    if (mode == 0) begin
      if (we) ref_mem[a] = merge(ref_mem[a], wd, sel);
      else    ref_rdata  = ref_mem[a];
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_stbn"}, stbc, exp_lat - 1);
    chk({tag, "_stable"}, bad, 0);
    chk({tag, "_err"}, cpu_err, (mode != 0));
    chk({tag, "_rdata"}, cpu_rdata, ref_rdata);
    chk({tag, "_idle"}, {cyc_o, stb_o, cpu_rdy}, 3'b001);
    @(negedge clk);
    chk({tag, "_pulse"}, {cpu_ack, cpu_rdy}, 2'b01);
  endtask

  // Request held high across three zero-wait reads.
  task automatic b2b();
    logic [WADDR-1:0] ad [3];
    int acks, n, bad;
    acks = 0; n = 0; bad = 0;
    for (int i = 0; i < 3; i++) ad[i] = $urandom;
    sl_waits = 0;
    sl_mode  = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_sel = 4'hF; cpu_addr = ad[0];
    while (acks < 3 && n < 50) begin
      @(negedge clk);
      n++;
      if (cpu_ack) begin
        ref_rdata = ref_mem[ad[acks]];
        chk("b2b_rdata", cpu_rdata, ref_rdata);
        if (stb_o || !cpu_rdy) bad++;
        acks++;
        if (acks < 3) cpu_addr = ad[acks];
        else          cpu_req  = 1'b0;
      end
    end
    cpu_req = 1'b0;
    chk("b2b_acks", acks, 3);
    chk("b2b_cycles", n, 6);
    chk("b2b_gap", bad, 0);
  endtask

  // ack_i/err_i outside a cycle must have no effect.
  task automatic spurious();
    logic [31:0] keep;
    keep = cpu_rdata;
    @(posedge clk);
    sl_spur = 1;
    @(posedge clk);
    sl_spur = 0;
    @(negedge clk);
    chk("spur_noack", {cpu_ack, cpu_err, cpu_rdy, cyc_o}, 4'b0010);
    chk("spur_rdata", cpu_rdata, keep);
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_sel = '0;
    dat_i = '0; ack_i = 1'b0; err_i = 1'b0;
    ref_rdata = '0;
    for (int i = 0; i < (1 << WADDR); i++) begin
      sram[i]    = $urandom;
      ref_mem[i] = sram[i];
    end
    sram[13'h0010]    = 32'hDEADBEEF;
    ref_mem[13'h0010] = 32'hDEADBEEF;
    sram[13'h1FFF]    = 32'hAABBCCDD;
    ref_mem[13'h1FFF] = 32'hAABBCCDD;

    repeat (3) @(negedge clk);
    chk("rst_bus", {cyc_o, stb_o, we_o, adr_o, dat_o, sel_o}, '0);
    chk("rst_cpu", {cpu_rdata, cpu_ack, cpu_err}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy", cpu_rdy, 1);

    // zero-wait read
    xfer("rd0", 1'b0, 13'h0010, 32'h0, 4'hF, 0, 0, 0);
    chk("rd0_val", cpu_rdata, 32'hDEADBEEF);

    // partial write with 3 wait states, then read back
    xfer("pw", 1'b1, 13'h1FFF, 32'h11223344, 4'b0101, 3, 0, 1);
    chk("pw_rdkeep", cpu_rdata, 32'hDEADBEEF);
    xfer("pwrd", 1'b0, 13'h1FFF, 32'h0, 4'hF, 0, 0, 0);
    chk("pw_val", cpu_rdata, 32'hAA22CC44);

    b2b();

    // ack+err together on a read: error wins, rdata kept
    xfer("both", 1'b0, 13'h0010, 32'h0, 4'hF, 1, 2, 0);
    xfer("err", 1'b0, 13'h0123, 32'h0, 4'hF, 2, 1, 0);

    // empty byte-select write still completes and changes nothing
    xfer("sel0", 1'b1, 13'h0010, 32'h12345678, 4'h0, 0, 0, 0);
    xfer("sel0rd", 1'b0, 13'h0010, 32'h0, 4'hF, 0, 0, 0);

    spurious();

    // randomized mix
    for (int t = 0; t < 40; t++) begin
      int r;
      r = $urandom_range(0, 9);
      xfer("rnd", 1'($urandom), WADDR'($urandom_range(0, 15)), $urandom,
           (t % 7 == 0) ? 4'h0 : 4'($urandom), $urandom_range(0, 3),
           (r < 7) ? 0 : ((r == 7) ? 1 : 2), 1'($urandom));
    end

    // reset during wait state 2
    @(negedge clk);
    sl_waits = 10; sl_mode = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0040; cpu_sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("mid_cyc", {cyc_o, stb_o}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("mid_async", {cyc_o, stb_o, cpu_ack}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    ref_rdata = '0;
    @(negedge clk);
    chk("mid_rel", {cpu_rdy, cpu_ack, cyc_o}, 3'b100);
    @(negedge clk);
    chk("mid_noack", cpu_ack, 0);

`ifdef MIPS_WBM_TIMEOUT_EN
    xfer("tmo", 1'b0, 13'h0055, 32'h0, 4'hF, 0, 3, 0);
`else
    @(negedge clk);
    sl_mode = 3;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0055; cpu_sel = 4'hF;
    @(negedge clk);
    cpu_req = 1'b0;
    repeat (1000) @(negedge clk);
    chk("hang_cyc", {cyc_o, stb_o, cpu_ack}, 3'b110);
    do_reset();
    sl_mode = 0;
`endif

    xfer("post", 1'b0, 13'h0010, 32'h0, 4'hF, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_wbmaster.md
Name: mips_wbmaster

Overview:
- Wishbone classic single-transfer master. It is the initiator end that drives the 4-lane byte-addressed SSRAM slaves used for program and data memory.
- Converts a simple CPU-side request/ready/ack interface into Wishbone cycles: 32-bit data, 4 byte selects, word address.
- One instance per CPU port: instruction fetch (main/exception program) and data memory.

Parameters:
- WADDR, 13: word-address width of adr_o and cpu_addr.
- TMO_CYCLES, 255: bus-timeout limit in cycles. Used only with MIPS_WBM_TIMEOUT_EN.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cpu_req  input  1  request strobe; sampled only when cpu_rdy=1.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  WADDR  word address.
- cpu_wdata  input  32  write data.
- cpu_sel  input  4  byte-lane enables; bit0 = dat[7:0].
- cpu_rdy  output  1  master idle; a request is accepted this cycle.
- cpu_ack  output  1  one-cycle completion pulse.
- cpu_err  output  1  qualifies cpu_ack; 1 = transfer failed.
- cpu_rdata  output  32  read data; valid with cpu_ack, held until the next successful read.
- cyc_o  output  1  Wishbone cycle.
- stb_o  output  1  Wishbone strobe.
- we_o  output  1  Wishbone write enable.
- adr_o  output  WADDR  Wishbone address.
- dat_o  output  32  Wishbone write data.
- sel_o  output  4  Wishbone byte selects.
- dat_i  input  32  Wishbone read data.
- ack_i  input  1  slave acknowledge.
- err_i  input  1  slave error.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. cyc_o=stb_o=we_o=0; adr_o, dat_o, sel_o, cpu_rdata = 0; cpu_ack=cpu_err=0; cpu_rdy=1 after release.
  - A reset mid-transfer drops cyc_o/stb_o immediately, with no completion pulse.
- All outputs are registered except cpu_rdy, which equals (state==IDLE).
- IDLE: when cpu_req=1 at edge N:
  - latch we/addr/wdata/sel into the Wishbone outputs;
  - assert cyc_o=stb_o=1 from cycle N+1;
  - go to BUS.
- BUS: outputs are held stable until ack_i=1 or err_i=1 at edge M. Then:
  - cyc_o=stb_o=0 after M; state returns to IDLE;
  - cpu_ack=1 for exactly the cycle after M;
  - on ack_i with a read: cpu_rdata <= dat_i at M;
  - cpu_err=1 if err_i, else 0.
- Latency: minimum 2 cycles from the req edge to the cpu_ack edge, for a zero-wait slave that acks in the first stb cycle. Slave wait states add 1:1.
- Back-to-back transfers:
  - the cpu_ack cycle is an IDLE cycle, so a request presented in that cycle is accepted;
  - stb_o is low for at least one cycle between transfers.
- Boundary conditions:
  - ack_i and err_i together: err wins; cpu_rdata is unchanged.
  - ack_i/err_i while not in BUS: ignored.
  - cpu_req while cpu_rdy=0: ignored, not queued.
  - cpu_sel=0: the cycle is still issued and completes normally.
  - Writes never modify cpu_rdata.

Optional Feature:
- Macro: MIPS_WBM_TIMEOUT_EN.
- Defined:
  - a cycle counter clears on entry to BUS and increments each BUS cycle;
  - when it reaches TMO_CYCLES without ack_i/err_i, the transfer is terminated exactly as for err_i (cpu_ack=1, cpu_err=1, cyc_o/stb_o drop).
  - A counter width of $clog2(TMO_CYCLES+1) must not wrap before the limit.
- Undefined: no counter is present; BUS waits indefinitely.

Decomposition:
- Shared include file mips_wbm_defs.v: state encodings (IDLE=0, BUS=1), the data width of 32, and the select width of 4.
- One natural sub-module: mips_wbm_tmo (the timeout counter). It is instantiated only under MIPS_WBM_TIMEOUT_EN.

Test Plan:
1. Zero-wait read: addr=0x0010 against an SSRAM slave holding 0xDEADBEEF. Required: stb_o high exactly 1 cycle, cpu_ack 2 cycles after req, cpu_rdata=0xDEADBEEF, cpu_err=0.
2. Partial write: addr=0x1FFF, wdata=0x11223344, sel=4'b0101, slave 3 wait states. Required: outputs stable 4 cycles. Reading back with sel=4'hF returns lanes 0 and 2 updated (0x??22??44 over the prior contents).
3. Back-to-back: req held high for 3 transfers. Required: each accepted in its ack cycle, stb_o low one cycle between transfers, 3 cpu_ack pulses.
4. Error: err_i with ack_i in the same cycle on a read. Required: cpu_err=1, cpu_rdata retains its prior value, state returns to IDLE.
5. Reset mid-BUS: rst_n low during wait state 2. Required: cyc_o/stb_o=0 asynchronously, no cpu_ack, cpu_rdy=1 after release.
6. MIPS_WBM_TIMEOUT_EN, TMO_CYCLES=8, slave never acks. Required: cpu_ack with cpu_err=1 after 8 BUS cycles. Without the macro: cyc_o still high after 1000 cycles.
